// File: rtl/franken_pkg.sv
// rtl/franken_pkg.sv - shared types and constants for the franken memory arbiter
package franken_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/franken_arb_pick.sv
// rtl/franken_arb_pick.sv - data-first winner select with a fetch starvation guard
module franken_arb_pick import franken_pkg::*; #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic pick_i,
  output logic pick_d
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_D_STREAK);

  logic [3:0] streak_q, streak_d;
  logic       force_i;

  // Streak only counts D wins that actually made a waiting fetch wait longer.
  always_comb begin
    force_i  = i_req && (streak_q == MAX_CNT);
    pick_d   = arb_en && d_req && !force_i;
    pick_i   = arb_en && i_req && !pick_d;
    streak_d = streak_q;
    if (pick_i) begin
      streak_d = '0;
    end else if (pick_d && i_req && (streak_q != MAX_CNT)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/franken_mem_arbiter.sv
// rtl/franken_mem_arbiter.sv - shares one memory port between fetch and load/store
module franken_mem_arbiter import franken_pkg::*; #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        we_q, we_d;
  logic              write_q, write_d;
  logic              i_gnt_q, i_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              store_done_q, store_done_d;
  logic              arb_en, pick_i, pick_d;

  // No arbitration in the store-done cycle: the core still holds d_req there.
  assign arb_en = (state_q == IDLE) && !store_done_q;

  franken_arb_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_pick (
    .clk   (clk),
    .reset (reset),
    .arb_en(arb_en),
    .i_req (i_req),
    .d_req (d_req),
    .pick_i(pick_i),
    .pick_d(pick_d)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    write_d      = write_q;
    i_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    store_done_d = 1'b0;
    mem_en       = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          owner_d = OWN_D;
          addr_d  = d_addr;
          wdata_d = d_we ? d_wdata : '0;
          we_d    = d_we ? d_be : 4'b0000;
          write_d = d_we;
          d_gnt_d = 1'b1;
          state_d = ISSUE;
        end else if (pick_i) begin
          owner_d = OWN_I;
          addr_d  = i_addr & ~32'h3;
          wdata_d = '0;
          we_d    = 4'b0000;
          write_d = 1'b0;
          i_gnt_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_en = 1'b1;
        if (mem_ready) begin
          if (write_q) begin
            store_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          if (owner_q == OWN_I) begin
            i_rvalid = 1'b1;
          end else begin
            d_rvalid = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= '0;
      write_q      <= 1'b0;
      i_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
      store_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      write_q      <= write_d;
      i_gnt_q      <= i_gnt_d;
      d_gnt_q      <= d_gnt_d;
      store_done_q <= store_done_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  assign i_stall   = i_req & ~i_rvalid;
  assign d_stall   = d_req & ~(d_rvalid | store_done_q);

endmodule
